// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared writeback entry type, limits and pointer helper
//
// Purpose: types and constants shared by the writeback / commit-trace logic.
// Ports: none (package).

package cpu_pkg;

   // One retired instruction as it sits in the commit queue.
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } wb_entry_t;

   localparam int         WB_LANES_MAX  = 4;
   localparam logic [3:0] TRACE_WEN_ALL = 4'b1111;

   // Circular-buffer pointer advance for depths that need not be a power
   // of two: a single conditional subtract, valid while k <= depth.
   function automatic int wrap_add(input int ptr, input int k, input int depth);
      int s;
      s = ptr + k;
      if (s >= depth) s = s - depth;
      return s;
   endfunction

endpackage

// File: rtl/wb_lane_compact.sv
// rtl/wb_lane_compact.sv - squeeze qualifying writeback lanes into a dense list
//
// Purpose: combinational compaction of LANES entries; qualifying lanes are
//          packed to slots 0,1,... in ascending lane order.
// Ports:
//   lane_entry   in   LANES entries, one per writeback lane
//   qualify      in   per-lane enqueue qualifier
//   packed_entry out  dense entries, slot j = j-th qualifying lane
//   push_cnt     out  number of qualifying lanes (0..LANES)

module wb_lane_compact
   import cpu_pkg::*;
#(
   parameter int LANES = 2
) (
   input  wb_entry_t [LANES-1:0]         lane_entry,
   input  logic      [LANES-1:0]         qualify,
   output wb_entry_t [LANES-1:0]         packed_entry,
   output logic      [$clog2(LANES+1)-1:0] push_cnt
);

   localparam int CNT_W = $clog2(LANES + 1);

   int cnt;

   always_comb begin
      packed_entry = '0;
      cnt          = 0;
      for (int i = 0; i < LANES; i++) begin
         if (qualify[i]) begin
            // Compare against every slot instead of indexing with cnt so the
            // select width never depends on the counter width.
            for (int j = 0; j < LANES; j++) begin
               if (j == cnt) packed_entry[j] = lane_entry[i];
            end
            cnt = cnt + 1;
         end
      end
      push_cnt = CNT_W'(cnt);
   end

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - multi-lane writeback plus in-order commit-trace queue
//
// Purpose: drives the regfile write ports from the MEM/WB register and logs
//          accepted instructions into a circular queue that retires up to
//          DRAIN entries per cycle to the debug trace port.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   in_valid/pc/wnum/wdata per-lane instruction from MEM/WB
//   in_ready               stage allowin (from registered count only)
//   rf_wen/waddr/wdata     regfile write ports
//   trace_ready            trace consumer accepts this cycle
//   debug_commit           per-slot retire valid
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata  retired instruction fields
//   occupancy              current queue entry count

module wb_commit_queue
   import cpu_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int DEPTH   = 8,
   parameter int DRAIN   = 1,
   parameter int LOG_ALL = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [LANES-1:0]             in_valid,
   input  logic [LANES*32-1:0]          in_pc,
   input  logic [LANES*5-1:0]           in_wnum,
   input  logic [LANES*32-1:0]          in_wdata,
   output logic                         in_ready,
   output logic [LANES-1:0]             rf_wen,
   output logic [LANES*5-1:0]           rf_waddr,
   output logic [LANES*32-1:0]          rf_wdata,
   input  logic                         trace_ready,
   output logic [DRAIN-1:0]             debug_commit,
   output logic [DRAIN*32-1:0]          debug_wb_pc,
   output logic [DRAIN*4-1:0]           debug_wb_rf_wen,
   output logic [DRAIN*5-1:0]           debug_wb_rf_wnum,
   output logic [DRAIN*32-1:0]          debug_wb_rf_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(LANES + 1);

   if (LANES < 1 || LANES > WB_LANES_MAX) begin : g_lanes_range
      $error("wb_commit_queue: LANES out of range");
   end

   wb_entry_t            mem [DEPTH];
   logic [PW-1:0]        head;
   logic [PW-1:0]        tail;
   logic [CW-1:0]        count;
   logic [31:0]          last_pc [DRAIN];

   wb_entry_t [LANES-1:0] lane_entry;
   wb_entry_t [LANES-1:0] packed_entry;
   logic      [LANES-1:0] qualify;
   logic      [LW-1:0]    push_cnt;
   int                    push_n;
   int                    pop_n;
   wb_entry_t             slot_entry [DRAIN];
   logic      [DRAIN-1:0] slot_commit;

   // Accept whenever a full group of LANES entries is guaranteed to fit.
   assign in_ready  = (count <= CW'(DEPTH - LANES));
   assign rf_waddr  = in_wnum;
   assign rf_wdata  = in_wdata;
   assign occupancy = count;

   always_comb begin
      lane_entry = '0;
      qualify    = '0;
      rf_wen     = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_entry[i].pc    = in_pc[i*32 +: 32];
         lane_entry[i].wnum  = in_wnum[i*5 +: 5];
         lane_entry[i].wdata = in_wdata[i*32 +: 32];
         qualify[i] = in_valid[i] & ((LOG_ALL != 0) | (in_wnum[i*5 +: 5] != 5'd0));
         rf_wen[i]  = in_valid[i] & (in_wnum[i*5 +: 5] != 5'd0) & in_ready;
      end
   end

   wb_lane_compact #(.LANES(LANES)) u_compact (
      .lane_entry   (lane_entry),
      .qualify      (qualify),
      .packed_entry (packed_entry),
      .push_cnt     (push_cnt)
   );

   // Pop looks only at count from the cycle start, so a freshly accepted
   // entry can never bypass straight to the trace port.
   always_comb begin
      push_n = in_ready ? int'(push_cnt) : 0;
      pop_n  = 0;
      if (resetn && trace_ready) pop_n = (int'(count) < DRAIN) ? int'(count) : DRAIN;
      for (int k = 0; k < DRAIN; k++) begin
         slot_entry[k]  = mem[PW'(wrap_add(int'(head), k, DEPTH))];
         slot_commit[k] = (k < pop_n);
      end
   end

   always_comb begin
      debug_commit      = slot_commit;
      debug_wb_pc       = '0;
      debug_wb_rf_wen   = '0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      for (int k = 0; k < DRAIN; k++) begin
         if (slot_commit[k]) begin
            debug_wb_pc[k*32 +: 32]       = slot_entry[k].pc;
            debug_wb_rf_wen[k*4 +: 4]     = (slot_entry[k].wnum != 5'd0) ? TRACE_WEN_ALL : 4'h0;
            debug_wb_rf_wnum[k*5 +: 5]    = slot_entry[k].wnum;
            debug_wb_rf_wdata[k*32 +: 32] = slot_entry[k].wdata;
         end else if (resetn) begin
            // An idle slot keeps showing the last PC it retired.
            debug_wb_pc[k*32 +: 32] = last_pc[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         for (int k = 0; k < DRAIN; k++) last_pc[k] <= '0;
      end else begin
         for (int k = 0; k < LANES; k++) begin
            if (k < push_n) mem[PW'(wrap_add(int'(tail), k, DEPTH))] <= packed_entry[k];
         end
         tail  <= PW'(wrap_add(int'(tail), push_n, DEPTH));
         head  <= PW'(wrap_add(int'(head), pop_n, DEPTH));
         count <= CW'(int'(count) + push_n - pop_n);
         for (int k = 0; k < DRAIN; k++) begin
            if (slot_commit[k]) last_pc[k] <= slot_entry[k].pc;
         end
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
      (int'(count) <= DEPTH) && (pop_n <= int'(count)) &&
      (int'(count) + push_n - pop_n <= DEPTH));

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - self-checking bench for wb_commit_queue

module tb_wb_commit_queue;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  in_valid = '0;
   logic [63:0] in_pc = '0;
   logic [9:0]  in_wnum = '0;
   logic [63:0] in_wdata = '0;
   logic        trace_ready = 1'b0;

   logic        a_ready;
   logic [1:0]  a_rf_wen;
   logic [9:0]  a_rf_waddr;
   logic [63:0] a_rf_wdata;
   logic [0:0]  a_commit;
   logic [31:0] a_pc;
   logic [3:0]  a_wen;
   logic [4:0]  a_wnum;
   logic [31:0] a_wdata;
   logic [3:0]  a_occ;

   logic        b_ready;
   logic [1:0]  b_rf_wen;
   logic [9:0]  b_rf_waddr;
   logic [63:0] b_rf_wdata;
   logic [1:0]  b_commit;
   logic [63:0] b_pc;
   logic [7:0]  b_wen;
   logic [9:0]  b_wnum;
   logic [63:0] b_wdata;
   logic [2:0]  b_occ;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_commit_queue #(.LANES(2), .DEPTH(8), .DRAIN(1), .LOG_ALL(1)) dut_a (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_pc(in_pc),
      .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(a_ready),
      .rf_wen(a_rf_wen), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
      .trace_ready(trace_ready), .debug_commit(a_commit), .debug_wb_pc(a_pc),
      .debug_wb_rf_wen(a_wen), .debug_wb_rf_wnum(a_wnum),
      .debug_wb_rf_wdata(a_wdata), .occupancy(a_occ)
   );

   wb_commit_queue #(.LANES(2), .DEPTH(6), .DRAIN(2), .LOG_ALL(0)) dut_b (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_pc(in_pc),
      .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(b_ready),
      .rf_wen(b_rf_wen), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
      .trace_ready(trace_ready), .debug_commit(b_commit), .debug_wb_pc(b_pc),
      .debug_wb_rf_wen(b_wen), .debug_wb_rf_wnum(b_wnum),
      .debug_wb_rf_wdata(b_wdata), .occupancy(b_occ)
   );

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] pc0;
      logic [4:0]  w0;
      logic [31:0] pc1;
      logic [4:0]  w1;
      logic        tr;
      logic        e_ready;
      logic [1:0]  e_rfwen;
      logic        e_commit;
      logic [31:0] e_pc;
      logic [3:0]  e_wen;
      logic [4:0]  e_wnum;
      logic [3:0]  e_occ;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } ent_t;

   vec_t tbl[$];

   function automatic void add(input logic [1:0] v, input logic [31:0] p0, input logic [4:0] w0,
                               input logic [31:0] p1, input logic [4:0] w1, input logic tr,
                               input logic rdy, input logic [1:0] rfw, input logic cm,
                               input logic [31:0] epc, input logic [3:0] ewen,
                               input logic [4:0] ewn, input logic [3:0] occ);
      vec_t r;
      r.valid = v; r.pc0 = p0; r.w0 = w0; r.pc1 = p1; r.w1 = w1; r.tr = tr;
      r.e_ready = rdy; r.e_rfwen = rfw; r.e_commit = cm; r.e_pc = epc;
      r.e_wen = ewen; r.e_wnum = ewn; r.e_occ = occ;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [4:0] w0,
                        input logic [31:0] d0, input logic [31:0] p1, input logic [4:0] w1,
                        input logic [31:0] d1, input logic tr);
      in_valid    = v;
      in_pc       = {p1, p0};
      in_wnum     = {w1, w0};
      in_wdata    = {d1, d0};
      trace_ready = tr;
   endtask

   task automatic idle(input logic tr);
      drive(2'b00, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, tr);
   endtask

   ent_t        q[$];
   logic [31:0] mlast [2];

   initial begin
      // ---------------- reset ----------------
      resetn = 1'b0;
      idle(1'b1);
      tick;
      #3;
      chk("reset_a_commit", a_commit, 0);
      chk("reset_a_pc", a_pc, 0);
      tick;
      resetn = 1'b1;

      // ---------------- table: single commit, fill/stall/drain on dut_a ----------------
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 0, 32'h0, 4'h0, 0, 0);
      add(2'b11, 32'hBFC00000, 2, 32'hBFC00004, 3, 1, 1, 2'b11, 0, 32'h0, 4'h0, 0, 0);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'hBFC00000, 4'hF, 2, 2);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'hBFC00004, 4'hF, 3, 1);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 0, 32'hBFC00004, 4'h0, 0, 0);
      add(2'b11, 32'h100, 1, 32'h104, 2, 0, 1, 2'b11, 0, 32'hBFC00004, 4'h0, 0, 0);
      add(2'b11, 32'h108, 3, 32'h10C, 4, 0, 1, 2'b11, 0, 32'hBFC00004, 4'h0, 0, 2);
      add(2'b11, 32'h110, 5, 32'h114, 0, 0, 1, 2'b01, 0, 32'hBFC00004, 4'h0, 0, 4);
      add(2'b11, 32'h118, 6, 32'h11C, 7, 0, 1, 2'b11, 0, 32'hBFC00004, 4'h0, 0, 6);
      add(2'b11, 32'h120, 8, 32'h124, 9, 0, 0, 2'b00, 0, 32'hBFC00004, 4'h0, 0, 8);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 0, 2'b00, 1, 32'h100, 4'hF, 1, 8);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 0, 2'b00, 1, 32'h104, 4'hF, 2, 7);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'h108, 4'hF, 3, 6);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'h10C, 4'hF, 4, 5);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'h110, 4'hF, 5, 4);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'h114, 4'h0, 0, 3);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'h118, 4'hF, 6, 2);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 1, 32'h11C, 4'hF, 7, 1);
      add(2'b00, 32'h0, 0, 32'h0, 0, 1, 1, 2'b00, 0, 32'h11C, 4'h0, 0, 0);

      for (int r = 0; r < tbl.size(); r++) begin
         vec_t v;
         v = tbl[r];
         drive(v.valid, v.pc0, v.w0, v.pc0 + 32'h1000, v.pc1, v.w1, v.pc1 + 32'h1000, v.tr);
         #3;
         chk($sformatf("t%0d_ready", r), a_ready, v.e_ready);
         chk($sformatf("t%0d_rf_wen", r), a_rf_wen, v.e_rfwen);
         chk($sformatf("t%0d_rf_waddr", r), a_rf_waddr, {v.w1, v.w0});
         chk($sformatf("t%0d_rf_wdata", r), a_rf_wdata, {v.pc1 + 32'h1000, v.pc0 + 32'h1000});
         chk($sformatf("t%0d_commit", r), a_commit, v.e_commit);
         chk($sformatf("t%0d_pc", r), a_pc, v.e_pc);
         chk($sformatf("t%0d_wen", r), a_wen, v.e_wen);
         chk($sformatf("t%0d_wnum", r), a_wnum, v.e_wnum);
         chk($sformatf("t%0d_wdata", r), a_wdata, v.e_commit ? v.e_pc + 32'h1000 : 32'h0);
         chk($sformatf("t%0d_occ", r), a_occ, v.e_occ);
         tick;
      end

      // ---------------- compaction with LOG_ALL=0 on dut_b ----------------
      resetn = 1'b0;
      idle(1'b0);
      tick;
      resetn = 1'b1;
      drive(2'b10, 32'h300, 5'd7, 32'hAA, 32'h200, 5'd5, 32'hBB, 1'b1);
      #3;
      chk("cmp_rf_wen", b_rf_wen, 2'b10);
      chk("cmp_occ0", b_occ, 0);
      tick;
      drive(2'b11, 32'h400, 5'd0, 32'hCC, 32'h404, 5'd6, 32'hDD, 1'b1);
      #3;
      chk("cmp_occ1", b_occ, 1);
      chk("cmp_commit", b_commit, 2'b01);
      chk("cmp_pc", b_pc[31:0], 32'h200);
      chk("cmp_wnum", b_wnum[4:0], 5);
      chk("cmp_wdata", b_wdata[31:0], 32'hBB);
      tick;
      idle(1'b1);
      #3;
      chk("cmp_occ2", b_occ, 1);
      chk("cmp_pc2", b_pc, {32'h0, 32'h404});
      tick;
      #3;
      chk("cmp_empty_commit", b_commit, 2'b00);

      // ---------------- reset with queued entries on dut_b ----------------
      drive(2'b11, 32'h500, 5'd1, 32'h1, 32'h504, 5'd2, 32'h2, 1'b0);
      tick;
      drive(2'b11, 32'h508, 5'd3, 32'h3, 32'h50C, 5'd4, 32'h4, 1'b0);
      tick;
      drive(2'b01, 32'h510, 5'd5, 32'h5, 32'h0, 5'd0, 32'h0, 1'b0);
      tick;
      idle(1'b0);
      #3;
      chk("rst_occ5", b_occ, 5);
      resetn = 1'b0;
      trace_ready = 1'b1;
      #1;
      chk("rst_cycle_commit", b_commit, 2'b00);
      chk("rst_cycle_pc", b_pc, 64'h0);
      tick;
      resetn = 1'b1;
      #3;
      chk("rst_occ0", b_occ, 0);
      chk("rst_commit0", b_commit, 2'b00);
      chk("rst_ready", b_ready, 1);
      for (int c = 0; c < 3; c++) begin
         tick;
         #3;
         chk($sformatf("rst_stale%0d", c), b_commit, 2'b00);
      end
      tick;

      // ---------------- randomized wrap-around on dut_b vs queue model ----------------
      mlast[0] = '0;
      mlast[1] = '0;
      begin
         int pcseq;
         pcseq = 32'h1000;
         for (int cyc = 0; cyc < 1000; cyc++) begin
            logic [1:0]  v;
            logic [31:0] p [2];
            logic [4:0]  w [2];
            logic [31:0] d [2];
            logic        tr;
            logic        exp_ready;
            int          npop;
            v = 2'($urandom_range(0, 3));
            for (int l = 0; l < 2; l++) begin
               p[l] = 32'(pcseq);
               pcseq += 4;
               w[l] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               d[l] = $urandom;
            end
            tr = ((cyc / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
            drive(v, p[0], w[0], d[0], p[1], w[1], d[1], tr);
            #3;
            exp_ready = (6 - q.size()) >= 2;
            npop = tr ? ((q.size() < 2) ? q.size() : 2) : 0;
            chk("rnd_ready", b_ready, exp_ready);
            chk("rnd_occ", b_occ, q.size());
            chk("rnd_rf_wen", b_rf_wen,
                {v[1] & (w[1] != 0) & exp_ready, v[0] & (w[0] != 0) & exp_ready});
            for (int k = 0; k < 2; k++) begin
               chk("rnd_commit", b_commit[k], k < npop);
               if (k < npop) begin
                  chk("rnd_pc", b_pc[k*32 +: 32], q[k].pc);
                  chk("rnd_wnum", b_wnum[k*5 +: 5], q[k].wnum);
                  chk("rnd_wdata", b_wdata[k*32 +: 32], q[k].wdata);
                  chk("rnd_wen", b_wen[k*4 +: 4], (q[k].wnum != 0) ? 4'hF : 4'h0);
               end else begin
                  chk("rnd_idle_pc", b_pc[k*32 +: 32], mlast[k]);
                  chk("rnd_idle_wen", b_wen[k*4 +: 4], 4'h0);
               end
            end
            tick;
            for (int k = 0; k < npop; k++) begin
               mlast[k] = q[0].pc;
               void'(q.pop_front());
            end
            if (exp_ready) begin
               for (int l = 0; l < 2; l++) begin
                  if (v[l] && w[l] != 0) begin
                     ent_t e;
                     e.pc = p[l]; e.wnum = w[l]; e.wdata = d[l];
                     q.push_back(e);
                  end
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
Parametrised writeback and commit-trace unit for the multi-issue pipeline.
- Writes up to LANES results per cycle into the register file in the accept cycle.
- Enqueues each accepted instruction into a circular commit queue. The queue drains up to DRAIN entries per cycle to the difftest/debug trace port under trace-side backpressure.
- Sits after the MEM/WB pipeline register, feeding the regfile write ports and the debug interface.

Parameters:
LANES, 2, number of writeback lanes, 1..4
DEPTH, 8, commit-queue entries, >= 2*LANES, any integer (not restricted to powers of two)
DRAIN, 1, entries retired to trace per cycle, 1..LANES
LOG_ALL, 1, 1 = enqueue every valid instr; 0 = enqueue only instrs with wnum != 0

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
in_valid  in  LANES  per-lane instruction valid
in_pc  in  LANES*32  per-lane PC
in_wnum  in  LANES*5  per-lane destination register (0 = no write)
in_wdata  in  LANES*32  per-lane write data
in_ready  out  1  stage allowin
rf_wen  out  LANES  regfile write enable per lane
rf_waddr  out  LANES*5  regfile write address
rf_wdata  out  LANES*32  regfile write data
trace_ready  in  1  trace consumer accepts this cycle
debug_commit  out  DRAIN  per-slot retire valid
debug_wb_pc  out  DRAIN*32  retired PC
debug_wb_rf_wen  out  DRAIN*4  4'b1111 if retired wnum != 0, else 0
debug_wb_rf_wnum  out  DRAIN*5  retired destination
debug_wb_rf_wdata  out  DRAIN*32  retired data
occupancy  out  clog2(DEPTH+1)  current entry count

Behaviour:
Reset and state
- Reset: head = tail = count = 0, all entries cleared. All debug outputs, debug_commit and occupancy are 0. in_ready is 1 in the cycle after reset release.
- Reset mid-operation discards all queued entries; no trace output in the reset cycle.
- State is head, tail and count registers. Pointers wrap explicitly: ptr+k >= DEPTH -> ptr+k-DEPTH.

Accept side
- in_ready = (DEPTH - count) >= LANES. It is a function of registered count only; there is no combinational path from trace_ready or in_valid.
- accept = in_ready. Lanes with in_valid=1 while in_ready=0 are not written and not enqueued; upstream holds them.
- rf_wen[i] = in_valid[i] & (in_wnum[i] != 0) & in_ready. rf_waddr and rf_wdata pass through combinationally.
- Same-cycle hazard: when two lanes write the same wnum, both enables assert. The regfile gives the higher lane priority, and the queue order is the same.

Enqueue
- Qualifying lanes: valid, and (LOG_ALL or wnum != 0).
- Qualifying lanes are compacted in ascending lane order to tail, tail+1, ...; push = number qualifying (0..LANES).

Drain side
- pop = min(count, DRAIN) when trace_ready=1, else 0.
- Slot k outputs entry head+k when k < count; debug_commit[k] = 1 if k < pop.
- Slots with debug_commit=0 drive wen/wnum/wdata = 0. PC holds the last retired PC of that slot (0 after reset).
- Retired entries leave in strict program order.

Timing
- Latency: an entry accepted in cycle t is first visible on slot 0 at t+1.
- Simultaneous push and pop in one cycle: count_next = count + push - pop.
- Pop only ever drains entries present at the cycle start; same-cycle bypass is forbidden.
- Full: count > DEPTH-LANES -> in_ready=0; draining continues.
- Empty: no commit.
- count never exceeds DEPTH or underflows. An assertion checks this in simulation.

Decomposition:
- Shared package (cpu_pkg):
  - wb_entry_t {pc[31:0], wnum[4:0], wdata[31:0]}
  - WB_LANES_MAX = 4
  - TRACE_WEN_ALL = 4'b1111
- Sub-module wb_lane_compact (combinational): takes LANES entries plus qualify mask; outputs the packed entry vector plus push count.
- Circular buffer and pointer logic stay in the top module.

Test Plan:
1. Reset then idle -> occupancy=0, in_ready=1, debug_commit=0, all debug outputs 0.
2. Single commit, LANES=2, DRAIN=1, trace_ready=1:
   - Stimulus: lane0 {pc=0xBFC00000, wnum=2, wdata=0x11}; lane1 {pc=0xBFC00004, wnum=3, wdata=0x22}.
   - rf_wen=2'b11 same cycle.
   - Debug: cycle+1 pc 0xBFC00000 wen 4'hF; cycle+2 pc 0xBFC00004.
3. Lane0 invalid, lane1 {wnum=5}, LOG_ALL=0 -> compacted into a single entry (push=1); the trace shows the lane1 PC on slot 0.
4. trace_ready=0, dual pushes every cycle, DEPTH=8 -> in_ready falls after 4 accepts (count=8 > 6); rf_wen=0 while stalled. Raising trace_ready retires all 8 in order, and in_ready returns once count <= 6.
5. Wrap-around, DEPTH=6, DRAIN=2, randomized push/pop for 1000 cycles -> trace order equals a reference model's program order; count stays within 0..6.
6. Reset asserted with count=5 -> next cycle occupancy=0, debug_commit=0, and no stale entry appears after release.
